pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the datapath's 32-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands over STAGES register stages, ripple-carrying one WIDTH/STAGES-bit chunk per stage.
- Valid/ready handshake with back-pressure.
- Produces sum, carry, signed-overflow and zero flags.
- Intended for multi-cycle/pipelined ALU paths where a full-width single-cycle add limits clock rate.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); latency in cycles.

Ports:
- clk  input  1  rising-edge clock; the single clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op present this cycle.
- in_ready  output  1  block accepts input this cycle.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB of a + (op ? ~b : b) + op; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - All stage valid bits cleared; out_valid = 0.
  - sum = 0, carry_out = 0, overflow = 0, zero = 0.
  - in_ready = 1 the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight item; no partial result ever appears.
- Advance:
  - advance = !out_valid || out_ready. The pipeline moves only when advance = 1, and then all stages move together.
  - in_ready = advance (combinational).
  - Input accepted on a cycle where in_valid && in_ready.
- Datapath:
  - Chunk width C = WIDTH/STAGES.
  - On accept, b is conditionally inverted (b ^ {WIDTH{op}}); carry-in = op.
  - Stage k (0..STAGES-1) adds chunk k of a and b' with the registered carry from stage k-1 (stage 0 uses carry-in).
  - Each stage registers its C-bit partial sum, its carry, the not-yet-summed upper chunks of a and b', and a valid bit.
  - Already-summed lower chunks travel forward alongside.
- Latency:
  - Accepted on edge N → out_valid = 1 after edge N+STAGES, provided advance stays 1.
  - Throughput is 1 op/cycle when out_ready is held 1.
- Flags, all registered with the final stage and valid only while out_valid = 1:
  - overflow = carry into MSB XOR carry out of MSB, which equals (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]).
  - zero is computed from the full final sum.
- Back-pressure:
  - When out_valid && !out_ready, every stage holds and the input is refused (in_ready = 0).
  - No item is dropped, duplicated or reordered.
  - sum and the flags remain stable while stalled.
- Bubbles: when in_valid = 0 with advance = 1, an empty slot enters the pipeline; empty slots never assert out_valid.
- STAGES = 1: single registered adder with latency 1; same handshake.
- Simultaneous events: rst overrides in_valid and out_ready in the same cycle.
- Wrap-around: sum is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Width/stage legality check (elaboration error if WIDTH % STAGES != 0).
- Sub-module addsub_stage: one chunk adder plus pipeline registers (partial sum, carry, valid, forwarded operand bits), parameterised by chunk width and stage index.
- pipelined_addsub instantiates STAGES copies via generate and owns the handshake and flag logic.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- add 0x000000FF + 0x00000001, out_ready=1 → out_valid exactly 4 cycles later; sum=0x00000100, carry_out=0, overflow=0, zero=0.
- add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, overflow=1, carry_out=0; add 0xFFFFFFFF + 0x00000001 → sum=0, carry_out=1, zero=1, overflow=0.
- sub 5 − 7 → sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0; sub 0x80000000 − 1 → sum=0x7FFFFFFF, overflow=1, carry_out=1.
- 6 back-to-back adds (i + 0x10 for i=0..5), out_ready low for 3 cycles after the first result → in_ready=0 while stalled; results 0x10..0x15 delivered in order with none lost or duplicated; sum stable during the stall.
- 3 ops in flight, rst pulsed 1 cycle → out_valid=0 from the next edge; no stale result afterwards; a new op issued after reset returns correctly 4 cycles later.
- STAGES=1, WIDTH=8: add 0xF0 + 0x20 → next cycle sum=0x10, carry_out=1, overflow=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the width/stage legality check
// used by the pipelined add/subtract datapath.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The datapath splits the word into equal chunks, one chunk per stage.
  function automatic bit addsub_geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage of the chunked ripple adder: sums chunk IDX and forwards
// the operands plus the partially built result to the next stage.
module addsub_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o
);

  localparam int LO = IDX * CHUNK;

  logic             valid_d, valid_q;
  logic             carry_d, carry_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    chunk_sum = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_i};
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    // Every stage moves in lock-step; when the pipe is stalled all state holds.
    if (advance) begin
      valid_d            = valid_i;
      carry_d            = chunk_sum[CHUNK];
      a_d                = a_i;
      b_d                = b_i;
      s_d                = s_i;
      s_d[LO +: CHUNK]   = chunk_sum[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign s_o     = s_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake; the carry
// ripples through STAGES registered chunk adders.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!addsub_geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic                         advance;
  logic [STAGES:0]              pipe_valid;
  logic [STAGES:0]              pipe_carry;
  logic [STAGES:0][WIDTH-1:0]   pipe_a;
  logic [STAGES:0][WIDTH-1:0]   pipe_b;
  logic [STAGES:0][WIDTH-1:0]   pipe_s;
  logic                         a_msb;
  logic                         b_msb;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1: invert b up front and inject op as the carry-in.
  assign pipe_valid[0] = in_valid;
  assign pipe_carry[0] = (op == OP_SUB);
  assign pipe_a[0]     = a;
  assign pipe_b[0]     = (op == OP_ADD) ? b : ~b;
  assign pipe_s[0]     = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .valid_i (pipe_valid[k]),
      .carry_i (pipe_carry[k]),
      .a_i     (pipe_a[k]),
      .b_i     (pipe_b[k]),
      .s_i     (pipe_s[k]),
      .valid_o (pipe_valid[k+1]),
      .carry_o (pipe_carry[k+1]),
      .a_o     (pipe_a[k+1]),
      .b_o     (pipe_b[k+1]),
      .s_o     (pipe_s[k+1])
    );
  end

  assign out_valid = pipe_valid[STAGES];
  assign sum       = pipe_s[STAGES];
  assign carry_out = pipe_carry[STAGES];
  assign a_msb     = pipe_a[STAGES][WIDTH-1];
  assign b_msb     = pipe_b[STAGES][WIDTH-1];

  // Flags derive from the final stage registers and read 0 whenever no result is held.
  assign overflow = out_valid && (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
  assign zero     = out_valid && (sum == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corners, back-pressure,
// mid-flight reset and random traffic against an arithmetic reference model.
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        ov;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic        op8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  sum8;
  logic        carry8;
  logic        ovf8;
  logic        zero8;

  int   total = 0;
  int   bad = 0;
  int   cycle_no = 0;
  int   last_out_cycle = -1;
  int   delivered = 0;
  exp_t expq[$];

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op        (op8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .carry_out (carry8),
    .overflow  (ovf8),
    .zero      (zero8)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on w-bit values, unsigned and signed views.
  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                 input int w);
    longint full;
    longint half;
    longint ux;
    longint uy;
    longint sx;
    longint sy;
    longint r_u;
    longint r_s;
    exp_t   e;
    full = longint'(1) << w;
    half = full >> 1;
    ux   = longint'(x) & (full - 1);
    uy   = longint'(y) & (full - 1);
    sx   = (ux >= half) ? ux - full : ux;
    sy   = (uy >= half) ? uy - full : uy;
    r_u  = o ? ux - uy : ux + uy;
    r_s  = o ? sx - sy : sx + sy;
    e.sum = 32'(r_u & (full - 1));
    e.c   = o ? (ux >= uy) : (r_u >= full);
    e.ov  = (r_s >= half) || (r_s < -half);
    e.z   = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle on the 32-bit DUT: drive, then score any delivered result.
  task automatic apply_stimulus(input logic r, input logic iv, input logic o,
                                input logic [31:0] aa, input logic [31:0] bb,
                                input logic ordy, output logic accepted);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check_output("spurious_result", 64'(out_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        check_output("sum", 64'(sum), 64'(e.sum));
        check_output("carry_out", 64'(carry_out), 64'(e.c));
        check_output("overflow", 64'(overflow), 64'(e.ov));
        check_output("zero", 64'(zero), 64'(e.z));
        delivered++;
        last_out_cycle = cycle_no;
      end
    end
    if (r) begin
      expq.delete();
    end else if (in_valid && in_ready) begin
      expq.push_back(model(o, aa, bb, 32));
      accepted = 1'b1;
    end
    cycle_no++;
  endtask

  task automatic drain(input int max_cycles);
    logic acc;
    int   n;
    n = 0;
    while (expq.size() > 0 && n < max_cycles) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      n++;
    end
    check_output("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    int          issue;
    int          idx;
    int          d0;
    logic        ordy;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e8a;
    exp_t        e8b;

    $display("[TB] reset");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_sum", 64'(sum), 64'd0);
    check_output("rst_carry", 64'(carry_out), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_zero", 64'(zero), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] latency");
    issue = cycle_no;
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1, acc);
    drain(10);
    check_output("latency", 64'(last_out_cycle - issue), 64'd4);

    $display("[TB] corners");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, acc);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, acc);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'd5, 32'd7, 1'b1, acc);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, acc);
    drain(12);

    $display("[TB] back-pressure");
    d0  = delivered;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      ordy = !(c >= 5 && c <= 7);
      apply_stimulus(1'b0, idx < 6, 1'b0, 32'(idx), 32'h10, ordy, acc);
      if (acc) idx++;
      if (c >= 5 && c <= 7) begin
        check_output("stall_in_ready", 64'(in_ready), 64'd0);
        check_output("stall_out_valid", 64'(out_valid), 64'd1);
        check_output("stall_sum", 64'(sum), 64'h11);
      end
    end
    drain(12);
    check_output("bp_issued", 64'(idx), 64'd6);
    check_output("bp_delivered", 64'(delivered - d0), 64'd6);

    $display("[TB] reset in flight");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 1'b1, acc);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'd9, 32'd3, 1'b1, acc);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      check_output("post_rst_out_valid", 64'(out_valid), 64'd0);
    end
    issue = cycle_no;
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0034, 1'b1, acc);
    drain(10);
    check_output("post_rst_latency", 64'(last_out_cycle - issue), 64'd4);

    $display("[TB] random");
    d0 = delivered;
    for (int c = 0; c < 80; c++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      apply_stimulus(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, rb,
                     $urandom_range(0, 9) < 7, acc);
    end
    drain(40);

    $display("[TB] 8-bit single stage");
    e8a = model(1'b0, 32'h0000_00F0, 32'h0000_0020, 8);
    e8b = model(1'b1, 32'h0000_0080, 32'h0000_0001, 8);
    @(negedge clk);
    in_valid8 = 1'b1; op8 = 1'b0; a8 = 8'hF0; b8 = 8'h20; out_ready8 = 1'b1;
    #1;
    check_output("w8_in_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b1; op8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    #1;
    check_output("w8_valid_a", 64'(out_valid8), 64'd1);
    check_output("w8_sum_a", 64'(sum8), 64'(e8a.sum[7:0]));
    check_output("w8_carry_a", 64'(carry8), 64'(e8a.c));
    check_output("w8_ovf_a", 64'(ovf8), 64'(e8a.ov));
    check_output("w8_zero_a", 64'(zero8), 64'(e8a.z));
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    check_output("w8_valid_b", 64'(out_valid8), 64'd1);
    check_output("w8_sum_b", 64'(sum8), 64'(e8b.sum[7:0]));
    check_output("w8_carry_b", 64'(carry8), 64'(e8b.c));
    check_output("w8_ovf_b", 64'(ovf8), 64'(e8b.ov));
    @(negedge clk);
    #1;
    check_output("w8_bubble", 64'(out_valid8), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
